// File: rtl/parity_frame_checker.sv
// Purpose: assembles a serial LSB-first bit stream into DATA_BITS-wide words and checks the trailing parity bit.
// Latency: the result is presented in the cycle after the edge that accepts the parity bit.
// Backpressure: in_ready drops while a result waits in HOLD; it depends only on registered state, never on out_ready.
module parity_frame_checker #(
  parameter int DATA_BITS = 8,
  parameter int ODD       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 frame_start,
  output logic                 in_ready,
  output logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_parity_ok
);

  // Count must reach DATA_BITS, so it needs one more code than the bit index.
  localparam int            CW      = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(DATA_BITS);
  localparam logic          LP_ODD  = (ODD != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_HOLD
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  state_t                 w_first_state;
  logic [DATA_BITS-1:0]   r_asm;
  logic                   r_acc;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          w_count_inc;
  logic                   r_out_valid;
  logic [DATA_BITS-1:0]   r_out_data;
  logic                   r_out_ok;
  logic                   r_abort;
  logic                   w_in_ready;
  logic                   w_xfer;
  logic                   w_start;
  logic                   w_restart;
  logic                   w_data_bit;
  logic                   w_par_bit;
  logic                   w_release;

  // A frame_start bit opens a frame; a single-bit frame goes straight to its parity bit.
  assign w_first_state = (DATA_BITS == 1) ? S_PARITY : S_DATA;
  assign w_count_inc   = r_count + 1'b1;

  assign w_xfer     = in_valid & w_in_ready;
  assign w_start    = w_xfer & frame_start;
  assign w_restart  = w_start & ((r_state == S_DATA) | (r_state == S_PARITY));
  assign w_data_bit = w_xfer & ~frame_start & (r_state == S_DATA);
  assign w_par_bit  = w_xfer & ~frame_start & (r_state == S_PARITY);
  assign w_release  = (r_state == S_HOLD) & r_out_valid & out_ready;

  // Next-state decode and the registered-state-only ready output.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = (r_state != S_HOLD);
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = w_first_state;
      end
      S_DATA: begin
        if (w_start) begin
          w_state_nxt = w_first_state;
        end else if (w_data_bit && (w_count_inc == LP_LAST)) begin
          w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_start) begin
          w_state_nxt = w_first_state;
        end else if (w_par_bit) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_release) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Assembly register, running parity and bit count; a start bit always reopens the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asm   <= '0;
      r_acc   <= 1'b0;
      r_count <= '0;
    end else if (w_start) begin
      r_asm    <= '0;
      r_asm[0] <= in_bit;
      r_acc    <= in_bit;
      r_count  <= CW'(1);
    end else if (w_data_bit) begin
      for (int i = 0; i < DATA_BITS; i++) begin
        if (r_count == CW'(i)) r_asm[i] <= in_bit;
      end
      r_acc   <= r_acc ^ in_bit;
      r_count <= w_count_inc;
    end
  end

  // Result registers: loaded by the parity bit, held (even after release) until the next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ok    <= 1'b0;
    end else if (w_par_bit) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_asm;
      r_out_ok    <= ((r_acc ^ in_bit) == LP_ODD);
    end else if (w_release) begin
      r_out_valid <= 1'b0;
    end
  end

  // Abort pulses for the one cycle after a frame is restarted mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_restart;
    end
  end

  assign in_ready      = w_in_ready;
  assign abort         = r_abort;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_parity_ok = r_out_ok;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: an even-parity and an odd-parity instance side by side.
// Expected results come from a frame-level model (bit list -> word, population count -> parity verdict).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_parity_frame_checker;

  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst         [2];
  logic          in_valid    [2];
  logic          in_bit      [2];
  logic          frame_start [2];
  logic          out_ready   [2];
  logic          in_ready    [2];
  logic          abort_o     [2];
  logic          out_valid   [2];
  logic          out_ok      [2];
  logic [DB-1:0] out_data    [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  parity_frame_checker #(.DATA_BITS(DB), .ODD(0)) dut_even (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_bit(in_bit[0]),
    .frame_start(frame_start[0]), .in_ready(in_ready[0]), .abort(abort_o[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_parity_ok(out_ok[0])
  );

  parity_frame_checker #(.DATA_BITS(DB), .ODD(1)) dut_odd (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_bit(in_bit[1]),
    .frame_start(frame_start[1]), .in_ready(in_ready[1]), .abort(abort_o[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_parity_ok(out_ok[1])
  );

  task automatic chk(input string tag, input int u, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[u%0d] got=0x%0h exp=0x%0h", tag, u, got, exp);
    end
  endtask

  // Reference verdict: total ones over data+parity must be even (u0) or odd (u1).
  function automatic logic ref_ok(input int u, input logic [DB-1:0] data, input logic par);
    int ones;
    ones = $countones(data) + int'(par);
    return (ones % 2) == u;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int u, input logic b, input logic fs, input logic exp_abort, input int gapmax);
    repeat ($urandom_range(0, gapmax)) begin
      in_valid[u] = 1'b0;
      in_bit[u]   = 1'($urandom);
      tick();
    end
    chk("rdy_before_bit", u, in_ready[u], 1);
    in_valid[u]    = 1'b1;
    in_bit[u]      = b;
    frame_start[u] = fs;
    tick();
    in_valid[u]    = 1'b0;
    frame_start[u] = 1'b0;
    chk("abort", u, abort_o[u], exp_abort);
    chk("no_early_valid", u, out_valid[u], 0);
    if (exp_abort) begin
      tick();
      chk("abort_one_cycle", u, abort_o[u], 0);
    end
  endtask

  // Sends an optional aborted prefix, a full frame and its parity bit, then holds the result
  // for 'hold' extra cycles under junk input before releasing it.
  task automatic send_frame(input int u, input logic [DB-1:0] data, input logic par,
                            input int hold, input int gapmax, input int restart_at);
    logic exp_ok;
    for (int i = 0; i < restart_at; i++) send_bit(u, 1'($urandom), (i == 0), 1'b0, gapmax);
    for (int i = 0; i < DB; i++) send_bit(u, data[i], (i == 0), (i == 0 && restart_at > 0), gapmax);
    repeat ($urandom_range(0, gapmax)) tick();
    chk("rdy_before_par", u, in_ready[u], 1);
    out_ready[u]   = (hold == 0);
    in_valid[u]    = 1'b1;
    in_bit[u]      = par;
    frame_start[u] = 1'b0;
    tick();
    exp_ok = ref_ok(u, data, par);
    chk("valid_rise", u, out_valid[u], 1);
    chk("data", u, out_data[u], data);
    chk("ok", u, out_ok[u], exp_ok);
    chk("rdy_hold", u, in_ready[u], 0);
    for (int k = 0; k < hold; k++) begin
      in_valid[u]    = 1'b1;
      in_bit[u]      = 1'($urandom);
      frame_start[u] = 1'($urandom);
      tick();
      chk("hold_valid", u, out_valid[u], 1);
      chk("hold_data", u, out_data[u], data);
      chk("hold_ok", u, out_ok[u], exp_ok);
      chk("hold_rdy", u, in_ready[u], 0);
    end
    out_ready[u]   = 1'b1;
    in_valid[u]    = 1'b1;
    in_bit[u]      = 1'($urandom);
    frame_start[u] = 1'($urandom);
    tick();
    in_valid[u]    = 1'b0;
    frame_start[u] = 1'b0;
    chk("released_valid", u, out_valid[u], 0);
    chk("released_rdy", u, in_ready[u], 1);
    chk("kept_data", u, out_data[u], data);
  endtask

  task automatic reset_check(input int u);
    rst[u] = 1'b1;
    #2;
    chk("rst_valid", u, out_valid[u], 0);
    chk("rst_data", u, out_data[u], 0);
    chk("rst_ok", u, out_ok[u], 0);
    chk("rst_abort", u, abort_o[u], 0);
    chk("rst_rdy", u, in_ready[u], 1);
  endtask

  initial begin
    logic [DB-1:0] d;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; in_valid[u] = 1'b0; in_bit[u] = 1'b0;
      frame_start[u] = 1'b0; out_ready[u] = 1'b1;
    end
    tick(); tick();
    for (int u = 0; u < 2; u++) reset_check(u);
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();

    // Basic even-parity frames: good parity then bad parity.
    send_frame(0, 8'hA5, 1'b0, 0, 0, 0);
    send_frame(0, 8'hA5, 1'b1, 0, 0, 0);

    // Backpressure: result held for 10 cycles with in_valid high.
    send_frame(0, 8'h3C, 1'b0, 10, 0, 0);

    // Restart on the 4th data bit; the restarting bit opens frame 0x0F.
    send_frame(0, 8'h0F, 1'b0, 0, 0, 3);

    // Leading junk in IDLE is ignored, then a gappy frame.
    for (int j = 0; j < 3; j++) send_bit(0, 1'($urandom), 1'b0, 1'b0, 0);
    send_frame(0, 8'h81, 1'b0, 0, 3, 0);

    // Reset while a result is being held drops it immediately.
    for (int i = 0; i < DB; i++) send_bit(0, d[i], (i == 0), 1'b0, 0);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_bit[0]    = 1'b1;
    tick();
    in_valid[0]  = 1'b0;
    chk("pre_rst_valid", 0, out_valid[0], 1);
    in_valid[0]    = 1'b1;
    frame_start[0] = 1'b1;
    reset_check(0);
    tick();
    rst[0] = 1'b0;
    in_valid[0]    = 1'b0;
    frame_start[0] = 1'b0;
    for (int j = 0; j < 2; j++) send_bit(0, 1'($urandom), 1'b0, 1'b0, 1);
    send_frame(0, 8'h5A, 1'b1, 1, 1, 0);

    // Odd-parity instance, with a reset five bits into a frame.
    send_frame(1, 8'hFF, 1'b1, 0, 0, 0);
    for (int i = 0; i < 5; i++) send_bit(1, 1'($urandom), (i == 0), 1'b0, 0);
    reset_check(1);
    tick();
    rst[1] = 1'b0;
    send_frame(1, 8'h01, 1'b0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("single_result", 1, out_valid[1], 0);
    end

    // Randomized frames on both instances.
    for (int r = 0; r < 12; r++) begin
      d = 8'($urandom);
      send_frame(r % 2, d, 1'($urandom), $urandom_range(0, 3), 2, (r % 4 == 3) ? $urandom_range(1, 6) : 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
